// File: rtl/al_commit_reader_pkg.sv
// Shared types and sizing for the active-list commit reader.
package al_commit_reader_pkg;

  localparam int unsigned AL_DEPTH        = 128;
  localparam int unsigned AL_INDEX        = 7;
  localparam int unsigned AL_COMMIT_WIDTH = 4;
  localparam int unsigned AL_CNT_W        = AL_INDEX + 1;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    SWEEP = 2'd2
  } al_state_t;

  // Active-list index carried by each commit lane.
  typedef logic [AL_INDEX-1:0] al_idx_t;

  // Number of lanes retired or swept in one cycle (0..COMMIT_WIDTH).
  typedef logic [$clog2(AL_COMMIT_WIDTH+1)-1:0] lane_cnt_t;

endpackage

// File: rtl/al_commit_reader_if.sv
// Ready-bit RAM read/clear ports plus the per-lane commit bus.
interface al_commit_reader_if
  import al_commit_reader_pkg::*;
#(
  parameter int unsigned COMMIT_WIDTH = AL_COMMIT_WIDTH,
  parameter int unsigned INDEX        = AL_INDEX
) ();

  logic [COMMIT_WIDTH-1:0][INDEX-1:0] rdAddr_o;
  logic [COMMIT_WIDTH-1:0]            rdData_i;
  logic [COMMIT_WIDTH-1:0]            commitVld_o;
  logic [COMMIT_WIDTH-1:0][INDEX-1:0] commitIdx_o;
  logic [COMMIT_WIDTH-1:0]            clrEn_o;
  logic [COMMIT_WIDTH-1:0][INDEX-1:0] clrAddr_o;

  modport master (
    output rdAddr_o,
    input  rdData_i,
    output commitVld_o,
    output commitIdx_o,
    output clrEn_o,
    output clrAddr_o
  );

  modport slave (
    input  rdAddr_o,
    output rdData_i,
    input  commitVld_o,
    input  commitIdx_o,
    input  clrEn_o,
    input  clrAddr_o
  );

endinterface

// File: rtl/al_ready_prefix.sv
// Leading-ones count of ready bits, masked by lane-active and occupancy.
module al_ready_prefix
  import al_commit_reader_pkg::*;
#(
  parameter int unsigned COMMIT_WIDTH = AL_COMMIT_WIDTH,
  parameter int unsigned CNT_W        = AL_CNT_W,
  parameter int unsigned NW           = $clog2(COMMIT_WIDTH+1)
) (
  input  logic [COMMIT_WIDTH-1:0] i_ready,
  input  logic [COMMIT_WIDTH-1:0] i_laneActive,
  input  logic [CNT_W-1:0]        i_occupancy,
  input  logic                    i_block,
  output logic [NW-1:0]           o_count
);

  logic w_run;

  // Counting stops at the first lane that fails any condition.
  always_comb begin
    o_count = '0;
    w_run   = !i_block;
    for (int unsigned i = 0; i < COMMIT_WIDTH; i++) begin
      if (w_run && i_ready[i] && i_laneActive[i] && (CNT_W'(i) < i_occupancy)) begin
        o_count = o_count + 1'b1;
      end else begin
        w_run = 1'b0;
      end
    end
  end

endmodule

// File: rtl/al_commit_reader.sv
// Commit-side reader of the active-list ready-bit RAM: retires the ready
// prefix at the head, clears retired bits, tracks occupancy, sweeps after flush.
module al_commit_reader
  import al_commit_reader_pkg::*;
#(
  parameter int unsigned DEPTH        = AL_DEPTH,
  parameter int unsigned INDEX        = AL_INDEX,
  parameter int unsigned COMMIT_WIDTH = AL_COMMIT_WIDTH,
  parameter int unsigned CNT_W        = AL_CNT_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ramReady_i,
  input  logic [COMMIT_WIDTH-1:0] commitLaneActive_i,
  input  logic [2:0]              dispatchCnt_i,
  input  logic                    stall_i,
  input  logic                    flush_i,
  al_commit_reader_if.master      bus,
  output logic [INDEX-1:0]        head_o,
  output logic [CNT_W-1:0]        occupancy_o,
  output logic [CNT_W-1:0]        freeCnt_o,
  output logic                    alReady_o
);

  localparam int unsigned NW = $clog2(COMMIT_WIDTH+1);

  al_state_t                          r_state;
  logic [INDEX-1:0]                   r_head;
  logic [CNT_W-1:0]                   r_occ;
  logic [INDEX-1:0]                   r_sweepPtr;
  logic [CNT_W-1:0]                   r_sweepLeft;
  logic [COMMIT_WIDTH-1:0]            r_commitVld;
  logic [COMMIT_WIDTH-1:0][INDEX-1:0] r_commitIdx;
  logic [COMMIT_WIDTH-1:0]            r_clrEn;
  logic [COMMIT_WIDTH-1:0][INDEX-1:0] r_clrAddr;

  logic          w_block;
  logic [NW-1:0] w_n;
  logic [NW-1:0] w_active;
  logic [NW-1:0] w_k;
  logic [CNT_W:0] w_room;

  assign w_block = stall_i | flush_i | (r_state != RUN);

  al_ready_prefix #(
    .COMMIT_WIDTH (COMMIT_WIDTH),
    .CNT_W        (CNT_W),
    .NW           (NW)
  ) u_prefix (
    .i_ready      (bus.rdData_i),
    .i_laneActive (commitLaneActive_i),
    .i_occupancy  (r_occ),
    .i_block      (w_block),
    .o_count      (w_n)
  );

  always_comb begin
    for (int unsigned i = 0; i < COMMIT_WIDTH; i++) begin
      bus.rdAddr_o[i] = r_head + INDEX'(i);
    end
  end

  // Lanes are contiguous from 0, so a popcount gives the sweep width.
  always_comb begin
    w_active = '0;
    for (int unsigned i = 0; i < COMMIT_WIDTH; i++) begin
      if (commitLaneActive_i[i]) begin
        w_active = w_active + 1'b1;
      end
    end
    if (CNT_W'(w_active) < r_sweepLeft) begin
      w_k = w_active;
    end else begin
      w_k = NW'(r_sweepLeft);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= INIT;
      r_head      <= '0;
      r_occ       <= '0;
      r_sweepPtr  <= '0;
      r_sweepLeft <= '0;
      r_commitVld <= '0;
      r_commitIdx <= '0;
      r_clrEn     <= '0;
      r_clrAddr   <= '0;
    end else begin
      r_commitVld <= '0;
      r_commitIdx <= '0;
      r_clrEn     <= '0;
      r_clrAddr   <= '0;
      case (r_state)
        INIT: begin
          if (ramReady_i) begin
            r_state <= RUN;
          end
        end
        RUN: begin
          if (flush_i) begin
            r_sweepPtr  <= r_head;
            r_sweepLeft <= r_occ;
            r_occ       <= '0;
            r_state     <= (r_occ != '0) ? SWEEP : RUN;
          end else begin
            r_head <= r_head + INDEX'(w_n);
            r_occ  <= r_occ + CNT_W'(dispatchCnt_i) - CNT_W'(w_n);
            for (int unsigned i = 0; i < COMMIT_WIDTH; i++) begin
              if (NW'(i) < w_n) begin
                r_commitVld[i] <= 1'b1;
                r_commitIdx[i] <= r_head + INDEX'(i);
                r_clrEn[i]     <= 1'b1;
                r_clrAddr[i]   <= r_head + INDEX'(i);
              end
            end
          end
        end
        SWEEP: begin
          for (int unsigned i = 0; i < COMMIT_WIDTH; i++) begin
            if (NW'(i) < w_k) begin
              r_clrEn[i]   <= 1'b1;
              r_clrAddr[i] <= r_sweepPtr + INDEX'(i);
            end
          end
          r_sweepPtr  <= r_sweepPtr + INDEX'(w_k);
          r_sweepLeft <= r_sweepLeft - CNT_W'(w_k);
          if (r_sweepLeft == CNT_W'(w_k)) begin
            r_state <= RUN;
          end
        end
        default: r_state <= INIT;
      endcase
    end
  end

  assign bus.commitVld_o = r_commitVld;
  assign bus.commitIdx_o = r_commitIdx;
  assign bus.clrEn_o     = r_clrEn;
  assign bus.clrAddr_o   = r_clrAddr;
  assign head_o          = r_head;
  assign occupancy_o     = r_occ;
  assign freeCnt_o       = CNT_W'(DEPTH) - r_occ;
  assign alReady_o       = (r_state == RUN);

  // Entries retired in the same cycle free their slots for that cycle's dispatch.
  assign w_room = {1'b0, freeCnt_o} + (CNT_W+1)'(w_n);

  a_dispatch_fits : assert property (
    @(posedge clk) disable iff (!reset)
    (r_state == RUN && !flush_i) |-> ((CNT_W+1)'(dispatchCnt_i) <= w_room)
  );

endmodule

// File: tb/tb_al_commit_reader.sv
// Scoreboard bench for al_commit_reader: expected lane outputs queued with stimulus.
module tb_al_commit_reader;
  import al_commit_reader_pkg::*;

  typedef struct packed {
    logic [3:0]      vld;
    logic [3:0][6:0] idx;
    logic [3:0]      clr;
    logic [3:0][6:0] caddr;
    logic [6:0]      head;
    logic [7:0]      occ;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ramReady = 1'b0;
  logic [3:0] lanes = 4'hF;
  logic [2:0] disp = 3'd0;
  logic       stall = 1'b0;
  logic       flush = 1'b0;
  logic [6:0] head;
  logic [7:0] occ;
  logic [7:0] free;
  logic       alReady;

  int   errs = 0;
  int   checks = 0;
  obs_t exp_q[$];
  obs_t e;
  obs_t o;

  al_commit_reader_if #(.COMMIT_WIDTH(4), .INDEX(7)) bus ();

  al_commit_reader #(
    .DEPTH        (128),
    .INDEX        (7),
    .COMMIT_WIDTH (4),
    .CNT_W        (8)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .ramReady_i         (ramReady),
    .commitLaneActive_i (lanes),
    .dispatchCnt_i      (disp),
    .stall_i            (stall),
    .flush_i            (flush),
    .bus                (bus),
    .head_o             (head),
    .occupancy_o        (occ),
    .freeCnt_o          (free),
    .alReady_o          (alReady)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  function automatic obs_t observe();
    obs_t r;
    r.vld   = bus.commitVld_o;
    r.idx   = bus.commitIdx_o;
    r.clr   = bus.clrEn_o;
    r.caddr = bus.clrAddr_o;
    r.head  = head;
    r.occ   = occ;
    return r;
  endfunction

  function automatic obs_t mk(logic [3:0] vld, logic [3:0] clr, int a0, int a1,
                              int a2, int a3, int h, int oc);
    obs_t r;
    int   a[4];
    a[0] = a0; a[1] = a1; a[2] = a2; a[3] = a3;
    r.vld = vld;
    r.clr = clr;
    for (int j = 0; j < 4; j++) begin
      r.idx[j]   = vld[j] ? 7'(a[j]) : 7'd0;
      r.caddr[j] = clr[j] ? 7'(a[j]) : 7'd0;
    end
    r.head = 7'(h);
    r.occ  = 8'(oc);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] d, input logic [3:0] rd);
    disp = d;
    bus.rdData_i = rd;
    step();
  endtask

  task automatic test_reset();
    bus.rdData_i = 4'b0;
    repeat (2) step();
    checks++;
    if ({alReady, head, occ, free, bus.commitVld_o, bus.clrEn_o} !==
        {1'b0, 7'd0, 8'd0, 8'd128, 4'b0, 4'b0}) begin
      errs++;
      $display("FAIL reset_state: got rdy=%b head=%0d occ=%0d free=%0d vld=%b clr=%b want 0 0 0 128 0 0",
               alReady, head, occ, free, bus.commitVld_o, bus.clrEn_o);
    end
    reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      checks++;
      if (alReady !== 1'b0) begin
        errs++;
        $display("FAIL init_wait: got alReady=%b want 0 (cycle %0d)", alReady, c);
      end
    end
    ramReady = 1'b1;
    step();
    checks++;
    if ({alReady, head, free} !== {1'b1, 7'd0, 8'd128}) begin
      errs++;
      $display("FAIL init_run: got rdy=%b head=%0d free=%0d want 1 0 128", alReady, head, free);
    end
  endtask

  task automatic test_prefix();
    drive(3'd6, 4'b0);
    checks++;
    if (occ !== 8'd6) begin
      errs++;
      $display("FAIL prefix_fill: got occ=%0d want 6", occ);
    end
    disp = 3'd0;
    bus.rdData_i = 4'b1011;
    checks++;
    if (bus.rdAddr_o !== {7'd3, 7'd2, 7'd1, 7'd0}) begin
      errs++;
      $display("FAIL prefix_rdaddr: got %h want %h", bus.rdAddr_o, {7'd3, 7'd2, 7'd1, 7'd0});
    end
    exp_q.push_back(mk(4'b0011, 4'b0011, 0, 1, 0, 0, 2, 4));
    step();
    e = exp_q.pop_front(); o = observe();
    checks++;
    if (o !== e) begin
      errs++;
      $display("FAIL prefix_commit: got %h want %h", o, e);
    end
    bus.rdData_i = 4'b1111;
    exp_q.push_back(mk(4'b1111, 4'b1111, 2, 3, 4, 5, 6, 0));
    step();
    e = exp_q.pop_front(); o = observe();
    checks++;
    if (o !== e) begin
      errs++;
      $display("FAIL prefix_drain: got %h want %h", o, e);
    end
  endtask

  task automatic test_wrap();
    for (int c = 0; c < 31; c++) drive(3'd4, 4'b1111);
    checks++;
    if ({head, occ} !== {7'd126, 8'd4}) begin
      errs++;
      $display("FAIL wrap_setup: got head=%0d occ=%0d want 126 4", head, occ);
    end
    disp = 3'd0;
    checks++;
    if (bus.rdAddr_o !== {7'd1, 7'd0, 7'd127, 7'd126}) begin
      errs++;
      $display("FAIL wrap_rdaddr: got %h want %h", bus.rdAddr_o, {7'd1, 7'd0, 7'd127, 7'd126});
    end
    exp_q.push_back(mk(4'b1111, 4'b1111, 126, 127, 0, 1, 2, 0));
    step();
    e = exp_q.pop_front(); o = observe();
    checks++;
    if (o !== e) begin
      errs++;
      $display("FAIL wrap_commit: got %h want %h", o, e);
    end
  endtask

  task automatic test_stall_lanes();
    bus.rdData_i = 4'b1111;
    exp_q.push_back(mk(4'b0, 4'b0, 0, 0, 0, 0, 2, 0));
    step();
    e = exp_q.pop_front(); o = observe();
    checks++;
    if (o !== e) begin
      errs++;
      $display("FAIL empty_nocommit: got %h want %h", o, e);
    end
    lanes = 4'b0011;
    drive(3'd6, 4'b0);
    disp = 3'd0;
    stall = 1'b1;
    bus.rdData_i = 4'b1111;
    exp_q.push_back(mk(4'b0, 4'b0, 0, 0, 0, 0, 2, 6));
    step();
    e = exp_q.pop_front(); o = observe();
    checks++;
    if (o !== e) begin
      errs++;
      $display("FAIL stall: got %h want %h", o, e);
    end
    stall = 1'b0;
    for (int c = 0; c < 3; c++) begin
      exp_q.push_back(mk(4'b0011, 4'b0011, 2 + 2*c, 3 + 2*c, 0, 0, 4 + 2*c, 4 - 2*c));
      step();
      e = exp_q.pop_front(); o = observe();
      checks++;
      if (o !== e) begin
        errs++;
        $display("FAIL two_lanes: got %h want %h (cycle %0d)", o, e, c);
      end
    end
    lanes = 4'b1111;
  endtask

  task automatic test_flush();
    drive(3'd2, 4'b0);
    drive(3'd0, 4'b0011);
    drive(3'd7, 4'b0);
    checks++;
    if ({head, occ} !== {7'd10, 8'd7}) begin
      errs++;
      $display("FAIL flush_setup: got head=%0d occ=%0d want 10 7", head, occ);
    end
    flush = 1'b1;
    disp = 3'd3;
    bus.rdData_i = 4'b1111;
    exp_q.push_back(mk(4'b0, 4'b0, 0, 0, 0, 0, 10, 0));
    exp_q.push_back(mk(4'b0, 4'b1111, 10, 11, 12, 13, 10, 0));
    exp_q.push_back(mk(4'b0, 4'b0111, 14, 15, 16, 0, 10, 0));
    for (int c = 0; c < 3; c++) begin
      step();
      if (c == 0) disp = 3'd0;
      e = exp_q.pop_front(); o = observe();
      checks++;
      if (o !== e || alReady !== (c == 2)) begin
        errs++;
        $display("FAIL flush_sweep: got %h rdy=%b want %h rdy=%b (cycle %0d)",
                 o, alReady, e, (c == 2), c);
      end
    end
    flush = 1'b0;
  endtask

  task automatic test_full();
    for (int c = 0; c < 18; c++) drive(3'd7, 4'b0);
    drive(3'd2, 4'b0);
    checks++;
    if ({occ, free} !== {8'd128, 8'd0}) begin
      errs++;
      $display("FAIL full_fill: got occ=%0d free=%0d want 128 0", occ, free);
    end
    disp = 3'd4;
    bus.rdData_i = 4'b1111;
    exp_q.push_back(mk(4'b1111, 4'b1111, 10, 11, 12, 13, 14, 128));
    step();
    disp = 3'd0;
    e = exp_q.pop_front(); o = observe();
    checks++;
    if (o !== e || free !== 8'd0) begin
      errs++;
      $display("FAIL full_commit: got %h free=%0d want %h free=0", o, free, e);
    end
  endtask

  task automatic test_reset_sweep();
    flush = 1'b1;
    bus.rdData_i = 4'b0;
    step();
    flush = 1'b0;
    step();
    checks++;
    if (bus.clrEn_o !== 4'b1111 || alReady !== 1'b0) begin
      errs++;
      $display("FAIL sweep_active: got clr=%b rdy=%b want 1111 0", bus.clrEn_o, alReady);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({alReady, head, occ, free, bus.clrEn_o, bus.commitVld_o} !==
        {1'b0, 7'd0, 8'd0, 8'd128, 4'b0, 4'b0}) begin
      errs++;
      $display("FAIL reset_mid_sweep: got rdy=%b head=%0d occ=%0d free=%0d clr=%b vld=%b want 0 0 0 128 0 0",
               alReady, head, occ, free, bus.clrEn_o, bus.commitVld_o);
    end
    step();
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_prefix();
    test_wrap();
    test_stall_lanes();
    test_flush();
    test_full();
    test_reset_sweep();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
